// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared NoC tree definitions: flit geometry, flit/address types and the
// round-robin pick used by the merge stages.
// No ports; imported by merge_slot and merge21_arbiter.
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int unsigned FLIT_W   = 9;
    localparam int unsigned ADDR_MSB = 8;
    localparam int unsigned ADDR_LSB = 5;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [3:0]        addr_t;

    // Source encoding carried on the out_src sideband.
    typedef enum logic {
        SrcIn0 = 1'b0,
        SrcIn1 = 1'b1
    } src_e;

    // Two-way round-robin pick. Returns a one-hot grant vector {g1, g0}, or
    // zero when neither requester is full. On a tie the side that did not
    // win last time is chosen.
    function automatic logic [1:0] rr_pick(input logic full0,
                                           input logic full1,
                                           input logic last_grant);
        logic [1:0] g;
        if (full0 && full1) begin
            g = last_grant ? 2'b01 : 2'b10;
        end else begin
            g = {full1, full0};
        end
        return g;
    endfunction

endpackage

// File: rtl/merge_slot.sv
// ---------------------------------------------------------------------------
// merge_slot
// One-entry holding buffer in front of the merge arbiter. A load captures a
// flit and sets full; a clear empties the slot. The owner guarantees load is
// only asserted while empty and clear only while full, so they never
// coincide.
//
// Ports:
//   CLK        clock, rising edge
//   _RESET     asynchronous active-low reset (slot empty, data zero)
//   load       capture load_data this edge
//   clear      release the held flit this edge
//   load_data  incoming flit
//   full       slot holds a flit
//   data       held flit
// ---------------------------------------------------------------------------
module merge_slot
    import noc_pkg::*;
#(
    parameter int unsigned W = FLIT_W
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/merge21_arbiter.sv
// ---------------------------------------------------------------------------
// merge21_arbiter
// 2-to-1 NoC merge stage. Each input feeds a one-entry slot; a round-robin
// arbiter moves one slot per cycle into a registered output stage. Flits pass
// through unmodified; out_src tells downstream which input a flit came from.
//
// Input readys depend only on slot state (no combinational path from
// out_ready), so a single input sustains one flit every two cycles while two
// active inputs together reach one flit per cycle.
//
// Optional build macro MERGE21_GRANT_CNT_EN adds two saturating per-input
// grant counters (grant_cnt0/grant_cnt1, CNT_W bits).
//
// Ports:
//   CLK, _RESET            clock / asynchronous active-low reset
//   in0_data/valid/ready   input channel 0 (upstream decoder A)
//   in1_data/valid/ready   input channel 1 (upstream decoder B)
//   out_data/valid/ready   merged output channel
//   out_src                0 = from in0, 1 = from in1
//   grant_cnt0/1           grant counters (MERGE21_GRANT_CNT_EN only)
// ---------------------------------------------------------------------------
module merge21_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned W     = FLIT_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [W-1:0]     in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [W-1:0]     in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
`ifdef MERGE21_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    // ------------------------------------------------------------------
    // Input slots
    // ------------------------------------------------------------------
    logic         slot0_full, slot1_full;
    logic [W-1:0] slot0_data, slot1_data;
    logic         slot0_load, slot1_load;
    logic [1:0]   grant;

    assign in0_ready  = !slot0_full;
    assign in1_ready  = !slot1_full;
    assign slot0_load = in0_valid && !slot0_full;
    assign slot1_load = in1_valid && !slot1_full;

    merge_slot #(
        .W (W)
    ) u_slot0 (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .load      (slot0_load),
        .clear     (grant[0]),
        .load_data (in0_data),
        .full      (slot0_full),
        .data      (slot0_data)
    );

    merge_slot #(
        .W (W)
    ) u_slot1 (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .load      (slot1_load),
        .clear     (grant[1]),
        .load_data (in1_data),
        .full      (slot1_full),
        .data      (slot1_data)
    );

    // ------------------------------------------------------------------
    // Arbitration and output register
    // ------------------------------------------------------------------
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    src_e         out_src_q,   out_src_d;
    src_e         last_grant_q, last_grant_d;
    logic         loadable;

    // Output stage may take a new flit when empty or being drained this edge.
    assign loadable = !out_valid_q || out_ready;

    always_comb begin
        grant        = 2'b00;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;

        if (loadable) begin
            grant = rr_pick(slot0_full, slot1_full, last_grant_q == SrcIn1);
            unique case (grant)
                2'b01: begin
                    out_valid_d  = 1'b1;
                    out_data_d   = slot0_data;
                    out_src_d    = SrcIn0;
                    last_grant_d = SrcIn0;
                end
                2'b10: begin
                    out_valid_d  = 1'b1;
                    out_data_d   = slot1_data;
                    out_src_d    = SrcIn1;
                    last_grant_d = SrcIn1;
                end
                default: begin
                    // Nothing to send: an idle stage stays idle and a
                    // draining stage empties. Data/src keep their last value.
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= SrcIn0;
            // Pretend in1 won last so in0 takes the first tie.
            last_grant_q <= SrcIn1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    // ------------------------------------------------------------------
    // Optional grant counters
    // ------------------------------------------------------------------
`ifdef MERGE21_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (grant[0]) cnt0_d = sat_inc(cnt0_q);
        if (grant[1]) cnt1_d = sat_inc(cnt1_q);
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    // Counter width only matters when the counters are built.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
